// File: rtl/uart_tx_unit.sv
// uart_tx_unit: byte-at-a-time UART transmitter (8N1, or 8E1 when UART_TX_PARITY_EN
// is defined) with a level start / done handshake toward the debug unit.
module uart_tx_unit #(
    parameter int SIZE_TRAMA   = 8,
    parameter int CLKS_PER_BIT = 5208,
    parameter int STOP_BITS    = 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_tx_start,
    input  logic [SIZE_TRAMA-1:0] i_tx_data,
    output logic                  o_tx,
    output logic                  o_tx_done,
    output logic [2:0]            o_debug_state
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (SIZE_TRAMA > 1) ? $clog2(SIZE_TRAMA) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(SIZE_TRAMA - 1);
    localparam bit TWO_STOP = (STOP_BITS == 2);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [SIZE_TRAMA-1:0] shift_q, shift_d;
    logic                  stop_cnt_q, stop_cnt_d;
    logic                  tx_q, tx_d;
    logic                  done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic                  parity_q, parity_d;
`endif

    logic                  bit_end;
    logic                  stop_last;
    logic [SIZE_TRAMA-1:0] shift_nx;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        stop_cnt_d = stop_cnt_q;
        tx_d       = tx_q;
        done_d     = done_q;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        bit_end   = (cnt_q == CNT_LAST);
        stop_last = !TWO_STOP || stop_cnt_q;
        shift_nx  = shift_q >> 1;

        // The bit-cycle counter free-runs while a frame is in flight.
        if (state_q != S_IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                done_d = 1'b1;
                if (i_tx_start) begin
                    shift_d    = i_tx_data;
                    state_d    = S_START;
                    tx_d       = 1'b0;
                    done_d     = 1'b0;
                    cnt_d      = '0;
                    idx_d      = '0;
                    stop_cnt_d = 1'b0;
`ifdef UART_TX_PARITY_EN
                    parity_d   = ^i_tx_data;
`endif
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d = shift_nx;
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        tx_d    = parity_q;
`else
                        state_d = S_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        tx_d = shift_nx[0];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    if (stop_last) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                done_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
            done_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign o_tx          = tx_q;
    assign o_tx_done     = done_q;
    assign o_debug_state = state_q;

endmodule

// File: tb/tb_uart_tx_unit.sv
// Bench for uart_tx_unit: drivers push expected bytes, per-DUT monitors decode the
// serial line against a slot-level frame model (one- and two-stop-bit instances).
`timescale 1ns/1ps
module tb_uart_tx_unit;

    localparam int C = 4;
    localparam int W = 8;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic         clk     = 1'b0;
    logic         rst     = 1'b1;
    logic         start_a = 1'b0;
    logic         start_b = 1'b0;
    logic [W-1:0] tx_data = '0;
    logic         tx_a, done_a, tx_b, done_b;
    logic [2:0]   st_a, st_b;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q_a[$];
    logic [W-1:0] exp_q_b[$];
    bit           abort_q_a[$];
    bit           abort_q_b[$];

    always #5 clk = ~clk;

    uart_tx_unit #(.SIZE_TRAMA(W), .CLKS_PER_BIT(C), .STOP_BITS(1)) dut_a (
        .i_clk(clk), .i_reset(rst), .i_tx_start(start_a), .i_tx_data(tx_data),
        .o_tx(tx_a), .o_tx_done(done_a), .o_debug_state(st_a)
    );

    uart_tx_unit #(.SIZE_TRAMA(W), .CLKS_PER_BIT(C), .STOP_BITS(2)) dut_b (
        .i_clk(clk), .i_reset(rst), .i_tx_start(start_b), .i_tx_data(tx_data),
        .o_tx(tx_b), .o_tx_done(done_b), .o_debug_state(st_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic cur_done(input int sel);
        return (sel != 0) ? done_b : done_a;
    endfunction
    function automatic logic cur_tx(input int sel);
        return (sel != 0) ? tx_b : tx_a;
    endfunction
    function automatic logic [2:0] cur_st(input int sel);
        return (sel != 0) ? st_b : st_a;
    endfunction

    // Frame model: slot 0 start, slots 1..W data LSB first, optional even parity, stop slots.
    function automatic int n_slots(input int stop_bits);
        return 1 + W + P + stop_bits;
    endfunction
    function automatic logic slot_level(input logic [W-1:0] d, input int s);
        if (s == 0) return 1'b0;
        if (s <= W) return d[s-1];
        if (P == 1 && s == W + 1) return (($countones(d) % 2) == 1);
        return 1'b1;
    endfunction
    function automatic logic [2:0] slot_state(input int s);
        if (s == 0) return 3'd1;
        if (s <= W) return 3'd2;
        if (P == 1 && s == W + 1) return 3'd3;
        return 3'd4;
    endfunction

    task automatic monitor(input int sel);
        logic         prev_done;
        logic [W-1:0] e;
        logic [W-1:0] dec;
        bit           ab;
        bit           saw3;
        int           sb, ns, f, n, line_err, st_err, run, k, exp_run;
        string        pfx;
        prev_done = 1'b1;
        pfx = (sel != 0) ? "b_" : "a_";
        sb  = (sel != 0) ? 2 : 1;
        ns  = n_slots(sb);
        f   = ns * C;
        forever begin
            @(negedge clk);
            if (prev_done === 1'b1 && cur_done(sel) === 1'b0) begin
                e = '0;
                ab = 1'b1;
                if (((sel != 0) ? exp_q_b.size() : exp_q_a.size()) == 0) begin
                    chk({pfx, "unexpected_frame"}, 1, 0);
                end else if (sel != 0) begin
                    e = exp_q_b.pop_front();
                    ab = abort_q_b.pop_front();
                end else begin
                    e = exp_q_a.pop_front();
                    ab = abort_q_a.pop_front();
                end
                n = 0; line_err = 0; st_err = 0; run = 0; dec = '0; saw3 = 1'b0;
                while (cur_done(sel) === 1'b0 && n < f + 4) begin
                    if (n < f) begin
                        if (cur_tx(sel) !== slot_level(e, n / C)) line_err++;
                        if (cur_st(sel) !== slot_state(n / C)) st_err++;
                    end
                    if (cur_st(sel) === 3'd3) saw3 = 1'b1;
                    if ((n % C) == (C / 2) && (n / C) >= 1 && (n / C) <= W)
                        dec[(n / C) - 1] = cur_tx(sel);
                    run = (cur_tx(sel) === 1'b1) ? run + 1 : 0;
                    n++;
                    @(negedge clk);
                end
                chk({pfx, "line"}, line_err, 0);
                chk({pfx, "state_seq"}, st_err, 0);
                chk({pfx, "idle_high_after"}, {31'd0, cur_tx(sel)}, 1);
                if (ab) begin
                    chk({pfx, "abort_truncated"}, {31'd0, (n < f)}, 1);
                end else begin
                    k = ns - 1;
                    while (k >= 0 && slot_level(e, k) == 1'b1) k--;
                    exp_run = (ns - 1 - k) * C;
                    chk({pfx, "done_low_cycles"}, n, f);
                    chk({pfx, "decoded_byte"}, {24'd0, dec}, {24'd0, e});
                    chk({pfx, "stop_run"}, run, exp_run);
                    chk({pfx, "parity_state_seen"}, {31'd0, saw3}, P);
                end
            end
            prev_done = cur_done(sel);
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    task automatic wait_done(input int sel, input logic lvl, input int budget, input string name);
        int t;
        t = 0;
        while (cur_done(sel) !== lvl && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk(name, {31'd0, cur_done(sel)}, {31'd0, lvl});
    endtask

    // Debug-unit style: hold start until done falls, then release it.
    task automatic send(input int sel, input logic [W-1:0] d, input bit ab);
        wait_done(sel, 1'b1, 200, "idle_wait");
        tx_data = d;
        if (sel != 0) begin
            start_b = 1'b1;
            exp_q_b.push_back(d);
            abort_q_b.push_back(ab);
        end else begin
            start_a = 1'b1;
            exp_q_a.push_back(d);
            abort_q_a.push_back(ab);
        end
        @(negedge clk);
        wait_done(sel, 1'b0, 10, "accept_wait");
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] hs [4];
        logic [W-1:0] d;
        int           t;
        hs[0] = 8'hDE; hs[1] = 8'hAD; hs[2] = 8'hBE; hs[3] = 8'hEF;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_tx_a", {31'd0, tx_a}, 1);
        chk("reset_done_a", {31'd0, done_a}, 1);
        chk("reset_state_a", {29'd0, st_a}, 0);
        chk("reset_tx_b", {31'd0, tx_b}, 1);
        chk("reset_done_b", {31'd0, done_b}, 1);
        chk("reset_state_b", {29'd0, st_b}, 0);
        rst = 1'b0;
        @(negedge clk);

        send(0, 8'h63, 1'b0);
        for (int i = 0; i < 4; i++) send(0, hs[i], 1'b0);
        send(0, 8'h01, 1'b0);

        // Data changes and a start pulse while busy must not disturb the frame.
        send(0, 8'h55, 1'b0);
        repeat (2) @(negedge clk);
        tx_data = 8'hAA;
        repeat (5) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_done(0, 1'b1, 100, "stab_done");

        // Reset in the middle of data bit 3.
        send(0, 8'hF0, 1'b1);
        repeat (4 * C + 1) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_tx", {31'd0, tx_a}, 1);
        chk("abort_done", {31'd0, done_a}, 1);
        chk("abort_state", {29'd0, st_a}, 0);
        rst = 1'b0;
        @(negedge clk);
        send(0, 8'h0F, 1'b0);

        // Start held high across two frames: second accepted right after done rises.
        wait_done(0, 1'b1, 200, "b2b_idle");
        tx_data = 8'h3C;
        start_a = 1'b1;
        exp_q_a.push_back(8'h3C); abort_q_a.push_back(1'b0);
        exp_q_a.push_back(8'h3C); abort_q_a.push_back(1'b0);
        @(negedge clk);
        wait_done(0, 1'b0, 10, "b2b_first");
        wait_done(0, 1'b1, 100, "b2b_rise");
        @(negedge clk);
        chk("b2b_second", {31'd0, done_a}, 0);
        start_a = 1'b0;

        for (int i = 0; i < 8; i++) begin
            d = W'($urandom_range(0, 255));
            wait_done(0, 1'b1, 200, "rand_idle");
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(0, d, 1'b0);
        end

        send(1, 8'h00, 1'b0);
        send(1, 8'h63, 1'b0);
        for (int i = 0; i < 3; i++) send(1, W'($urandom_range(0, 255)), 1'b0);

        wait_done(0, 1'b1, 200, "final_a");
        wait_done(1, 1'b1, 200, "final_b");
        t = 0;
        while ((exp_q_a.size() != 0 || exp_q_b.size() != 0) && t < 500) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        chk("drain_a", exp_q_a.size(), 0);
        chk("drain_b", exp_q_b.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
